// File: rtl/alu_cmd_master_if.sv
// Host/UART-side signal bundle of the ALU command initiator.
// Handshakes: i_start is taken only while o_busy==0; every o_tx_start pulse is
// answered by exactly one later i_tx_done pulse; i_rx_done qualifies i_rx_data for
// one cycle; o_valid qualifies o_result for one cycle; o_timeout is a bare pulse.
interface alu_cmd_master_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
);
  logic             i_start;
  logic [DBIT-1:0]  i_a;
  logic [DBIT-1:0]  i_b;
  logic [NB_OP-1:0] i_op;
  logic             i_tx_done;
  logic             i_rx_done;
  logic [DBIT-1:0]  i_rx_data;
  logic             o_tx_start;
  logic [DBIT-1:0]  o_tx_data;
  logic             o_busy;
  logic [DBIT-1:0]  o_result;
  logic             o_valid;
  logic             o_timeout;

  modport master (
    input  i_start, i_a, i_b, i_op, i_tx_done, i_rx_done, i_rx_data,
    output o_tx_start, o_tx_data, o_busy, o_result, o_valid, o_timeout
  );

  modport slave (
    output i_start, i_a, i_b, i_op, i_tx_done, i_rx_done, i_rx_data,
    input  o_tx_start, o_tx_data, o_busy, o_result, o_valid, o_timeout
  );
endinterface

// File: rtl/alu_cmd_master.sv
// UART ALU link initiator: sends A, B, OP as three tx bytes, then waits for the
// one-byte result with a cycle-count timeout.
module alu_cmd_master #(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_BITS     = 20
) (
  input  logic                i_clk,
  input  logic                i_rst,
  alu_cmd_master_if.master    bus,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES
  } state_t;

  state_t             state_q, state_d;
  logic [DBIT-1:0]    b_q, op_q;
  logic [DBIT-1:0]    tx_data_q, tx_data_d;
  logic [DBIT-1:0]    result_q;
  logic [TO_BITS-1:0] cnt_q;
  logic               tx_start, valid, timeout;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;
    valid     = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        state_d   = SEND_A;
        tx_data_d = bus.i_a;
      end
      SEND_A: begin
        tx_start = 1'b1;
        state_d  = WAIT_A;
      end
      WAIT_A: if (bus.i_tx_done) begin
        state_d   = SEND_B;
        tx_data_d = b_q;
      end
      SEND_B: begin
        tx_start = 1'b1;
        state_d  = WAIT_B;
      end
      WAIT_B: if (bus.i_tx_done) begin
        state_d   = SEND_OP;
        tx_data_d = op_q;
      end
      SEND_OP: begin
        tx_start = 1'b1;
        state_d  = WAIT_OP;
      end
      WAIT_OP: if (bus.i_tx_done) state_d = WAIT_RES;
      WAIT_RES: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (bus.i_rx_done) begin
          valid   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO_BITS'(TIMEOUT_CYC - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      if (state_q == IDLE && bus.i_start) begin
        b_q  <= bus.i_b;
        op_q <= DBIT'(bus.i_op);
      end
      if (valid) result_q <= bus.i_rx_data;
      // Counter reads 0 on the first WAIT_RES cycle.
      cnt_q <= (state_q == WAIT_RES) ? cnt_q + 1'b1 : '0;
    end
  end

  assign bus.o_tx_start = tx_start;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_result   = result_q;
  assign bus.o_valid    = valid;
  assign bus.o_timeout  = timeout;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Bench for alu_cmd_master: table vectors, hand-written reset sequence and
// randomized transactions against a transaction-level reference model.
module tb_alu_cmd_master;
  localparam int DBIT    = 8;
  localparam int NB_OP   = 6;
  localparam int TO_CYC  = 100;
  localparam int TO_BITS = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_master_if #(.DBIT(DBIT), .NB_OP(NB_OP)) bus ();
  logic [2:0] dbg_state;

  alu_cmd_master #(
    .DBIT(DBIT), .NB_OP(NB_OP), .TIMEOUT_CYC(TO_CYC), .TO_BITS(TO_BITS)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    int         tx_delay;
    int         rx_at;       // cycles after the OP tx_done; -1 = no result byte
    logic [7:0] rx_byte;
    bit         stale;       // rx byte 55 during WAIT_B
    bit         early;       // i_start with other operands during WAIT_A
    bit         start_end;   // i_start in the cycle the result/timeout pulses
    logic [7:0] exp_op_byte;
    bit         exp_timeout;
    int         exp_off;     // pulse cycle index counted from first WAIT_RES cycle
    logic [7:0] exp_result;
  } vec_t;

  // scoreboard
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] model_result;
  logic [DBIT-1:0] exp_q[$];
  vec_t       tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_quiet();
    bus.i_start   = 1'b0;
    bus.i_tx_done = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int cyc, done_at, d3, exp_send, n_start, n_done, end_cyc, c1, c2;
    bit ended, got_timeout, res_stable, excl_ok, prev_pulse;
    logic [DBIT-1:0] eb;
    exp_q.delete();
    exp_q.push_back(v.a);
    exp_q.push_back(v.b);
    exp_q.push_back(v.exp_op_byte);
    @(negedge clk);
    drive_quiet();
    bus.i_start = 1'b1;
    bus.i_a = v.a; bus.i_b = v.b; bus.i_op = v.op;
    #1;
    chk($sformatf("t%0d idle busy", id), 32'(bus.o_busy), 32'd0);
    chk($sformatf("t%0d idle tx_start", id), 32'(bus.o_tx_start), 32'd0);
    chk($sformatf("t%0d idle pulses", id), 32'({bus.o_valid, bus.o_timeout}), 32'd0);
    chk($sformatf("t%0d prior result", id), 32'(bus.o_result), 32'(model_result));
    cyc = 0; done_at = -1; d3 = -1; exp_send = 1; n_start = 0; n_done = 0;
    c1 = -1; c2 = -1; end_cyc = -1;
    ended = 0; got_timeout = 0; res_stable = 1; excl_ok = 1; prev_pulse = 0;
    while (!ended && cyc < 700) begin
      @(negedge clk);
      cyc++;
      drive_quiet();
      bus.i_tx_done = (cyc == done_at);
      if (v.early && c1 >= 0 && cyc == c1 + 1) begin
        bus.i_start = 1'b1;
        bus.i_a = ~v.a; bus.i_b = ~v.b; bus.i_op = ~v.op;
      end
      if (v.stale && c2 >= 0 && cyc == c2 + 1) begin
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'h55;
      end
      if (d3 >= 0 && v.rx_at >= 1 && cyc == d3 + v.rx_at) begin
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = v.rx_byte;
      end
      if (v.start_end && d3 >= 0 && cyc == d3 + 1 + v.exp_off) begin
        bus.i_start = 1'b1;
        bus.i_a = 8'hEE; bus.i_b = 8'hDD; bus.i_op = 6'h15;
      end
      if (cyc == done_at) begin
        n_done++;
        if (n_done == 3) d3 = cyc;
        else exp_send = cyc + 1;
      end
      #1;
      if (bus.o_valid && bus.o_timeout) excl_ok = 0;
      if ((bus.o_valid || bus.o_timeout) && prev_pulse) excl_ok = 0;
      prev_pulse = bus.o_valid | bus.o_timeout;
      if (bus.o_result !== model_result) res_stable = 0;
      if (bus.o_tx_start) begin
        n_start++;
        if (n_start <= 3) begin
          eb = exp_q.pop_front();
          chk($sformatf("t%0d send%0d cycle", id, n_start), 32'(cyc), 32'(exp_send));
          chk($sformatf("t%0d send%0d byte", id, n_start), 32'(bus.o_tx_data), 32'(eb));
          if (n_start == 1) c1 = cyc;
          if (n_start == 2) c2 = cyc;
          done_at = cyc + v.tx_delay;
        end
      end
      if (bus.o_valid || bus.o_timeout) begin
        ended = 1;
        got_timeout = bus.o_timeout;
        end_cyc = cyc;
      end
    end
    chk($sformatf("t%0d ended", id), 32'(ended), 32'd1);
    chk($sformatf("t%0d tx_start count", id), 32'(n_start), 32'd3);
    chk($sformatf("t%0d timeout kind", id), 32'(got_timeout), 32'(v.exp_timeout));
    chk($sformatf("t%0d end offset", id), 32'(end_cyc - (d3 + 1)), 32'(v.exp_off));
    chk($sformatf("t%0d result held", id), 32'(res_stable), 32'd1);
    chk($sformatf("t%0d pulse excl", id), 32'(excl_ok), 32'd1);
    model_result = v.exp_result;
  endtask

  task automatic mid_reset();
    int cyc, done_at, n_start;
    @(negedge clk);
    drive_quiet();
    bus.i_start = 1'b1;
    bus.i_a = 8'hC1; bus.i_b = 8'hC2; bus.i_op = 6'h03;
    cyc = 0; done_at = -1; n_start = 0;
    while (n_start < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      drive_quiet();
      bus.i_tx_done = (cyc == done_at);
      #1;
      if (bus.o_tx_start) begin
        n_start++;
        done_at = cyc + 2;
      end
    end
    chk("rst reached send_op", 32'(n_start), 32'd3);
    // WAIT_OP cycle: reset for exactly one edge
    @(negedge clk);
    drive_quiet();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst busy", 32'(bus.o_busy), 32'd0);
    chk("rst tx_start", 32'(bus.o_tx_start), 32'd0);
    chk("rst result", 32'(bus.o_result), 32'd0);
    chk("rst tx_data", 32'(bus.o_tx_data), 32'd0);
    model_result = '0;
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{a:8'h05, b:8'h03, op:6'h20, tx_delay:20, rx_at:50, rx_byte:8'h08,
               stale:0, early:0, start_end:0, exp_op_byte:8'h20, exp_timeout:0,
               exp_off:49, exp_result:8'h08};
    tbl[1] = '{a:8'h11, b:8'h22, op:6'h3F, tx_delay:5, rx_at:-1, rx_byte:8'h00,
               stale:0, early:0, start_end:1, exp_op_byte:8'h3F, exp_timeout:1,
               exp_off:99, exp_result:8'h08};
    tbl[2] = '{a:8'h3C, b:8'h4D, op:6'h01, tx_delay:3, rx_at:100, rx_byte:8'hAA,
               stale:0, early:0, start_end:1, exp_op_byte:8'h01, exp_timeout:0,
               exp_off:99, exp_result:8'hAA};
    tbl[3] = '{a:8'h12, b:8'h34, op:6'h07, tx_delay:6, rx_at:10, rx_byte:8'h77,
               stale:1, early:1, start_end:0, exp_op_byte:8'h07, exp_timeout:0,
               exp_off:9, exp_result:8'h77};
    tbl[4] = '{a:8'hFF, b:8'h01, op:6'h22, tx_delay:4, rx_at:30, rx_byte:8'hC3,
               stale:0, early:0, start_end:0, exp_op_byte:8'h22, exp_timeout:0,
               exp_off:29, exp_result:8'hC3};

    rst_n = 1'b0;
    drive_quiet();
    bus.i_a = '0; bus.i_b = '0; bus.i_op = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", 32'(bus.o_busy), 32'd0);
    chk("reset tx_start", 32'(bus.o_tx_start), 32'd0);
    chk("reset tx_data", 32'(bus.o_tx_data), 32'd0);
    chk("reset result", 32'(bus.o_result), 32'd0);
    chk("reset pulses", 32'({bus.o_valid, bus.o_timeout}), 32'd0);
    rst_n = 1'b1;
    model_result = '0;

    for (int i = 0; i < 3; i++) run_txn(tbl[i], i);
    mid_reset();
    for (int i = 3; i < 5; i++) run_txn(tbl[i], i);

    for (int i = 0; i < 10; i++) begin
      v.a         = 8'($urandom_range(0, 255));
      v.b         = 8'($urandom_range(0, 255));
      v.op        = 6'($urandom_range(0, 63));
      v.tx_delay  = $urandom_range(1, 8);
      v.rx_at     = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, TO_CYC + 5);
      v.rx_byte   = 8'($urandom_range(0, 255));
      v.stale     = 1'($urandom_range(0, 1));
      v.early     = 1'($urandom_range(0, 1));
      v.start_end = 1'($urandom_range(0, 1));
      // reference: result counts if it lands within TO_CYC cycles of WAIT_RES entry
      v.exp_op_byte = {2'b00, v.op};
      if (v.rx_at >= 1 && v.rx_at <= TO_CYC) begin
        v.exp_timeout = 0;
        v.exp_off     = v.rx_at - 1;
        v.exp_result  = v.rx_byte;
      end else begin
        v.exp_timeout = 1;
        v.exp_off     = TO_CYC - 1;
        v.exp_result  = model_result;
      end
      run_txn(v, 10 + i);
    end

    @(negedge clk);
    drive_quiet();
    #1;
    chk("final busy", 32'(bus.o_busy), 32'd0);
    chk("final result", 32'(bus.o_result), 32'(model_result));
    chk("final pulses", 32'({bus.o_valid, bus.o_timeout}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
